core_mem_nport: RTL
===================

Name: core_mem_nport

Overview:
- Parametrised successor core-memory module, read-restore style, for the membus.
- Serves NPORTS processor ports with round-robin arbitration.
- Memory size and select code are set by parameters instead of fixed jumpers.
- Runs full cycles from a clock-cycle sequencer (IDLE -> ADDR -> RD -> PSE -> WR -> REC), with optional single-step stop and restart.

Parameters:
- NPORTS, 4: number of membus ports, 1..8.
- AW, 14: core address bits; depth is 2**AW words.
- DW, 36: word width.
- SEL_ID, 4'b0000: select code this module answers to.
- T_RD, 5: clk cycles from end of ADDR to sense strobe; must be >= 1.
- T_WR, 5: clk cycles the WR state lasts (write/restore); must be >= 1.
- T_REC, 2: clk cycles of recovery before IDLE; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sw_single_step  in  1  stop after each cycle.
- sw_restart  in  1  level; rising edge while stopped resumes.
- rq_cyc  in  NPORTS  per-port cycle request.
- rd_rq  in  NPORTS  per-port read request.
- wr_rq  in  NPORTS  per-port write request.
- wr_rs  in  NPORTS  per-port write-restart; write data valid.
- fmc_select  in  NPORTS  per-port fast-memory select; inhibits this module.
- sel  in  NPORTS*4  per-port select code; port i at [4i+3:4i].
- ma  in  NPORTS*AW  per-port address.
- mb_in  in  NPORTS*DW  per-port write data.
- addr_ack  out  NPORTS  one-cycle address acknowledge.
- rd_rs  out  NPORTS  one-cycle read-restart; read data valid.
- mb_out  out  NPORTS*DW  read data; zero except the active port during rd_rs.
- stopped  out  1  single-step stop flag.
- busy  out  1  high in any state other than IDLE and STOP.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE; all outputs 0; active port cleared.
  - Round-robin pointer=0; cmb=0; stopped=0.
  - Core contents are preserved.
  - Reset mid-cycle abandons the cycle with no core write.
- Request: req[i] = rq_cyc[i] & ~fmc_select[i] & (sel[i]==SEL_ID).
- IDLE:
  - If any req, grant the first requesting port at or after rr_ptr, modulo NPORTS.
  - Latch act, cma=ma[act], cma_rd=rd_rq[act], cma_wr=wr_rq[act]; go to ADDR.
  - rr_ptr <= act+1, with wrap.
  - Requests arriving while not in IDLE are ignored until IDLE.
- ADDR (1 cycle):
  - addr_ack[act]=1.
  - Then RD, with counter=T_RD.
- RD:
  - Count down.
  - At expiry, cmb<=core[cma] and core[cma]<=0, modelling the destructive read.
  - If cma_rd: rd_rs[act]=1 and mb_out[act]=core word for exactly that cycle.
  - Next state is PSE.
- PSE:
  - If ~cma_wr, go straight to WR; this is the restore of read data.
  - If cma_wr, wait for wr_rs[act]. On that cycle cmb<=mb_in[act], replacing rather than ORing, then go to WR.
  - While waiting, if rq_cyc[act] drops, go to WR with cmb unchanged; the old data is restored.
  - Write-only cycles (rd_rq=0) still take the RD timing; rd_rs is not pulsed.
- WR:
  - T_WR cycles.
  - core[cma]<=cmb on the last cycle.
  - Then REC.
- REC:
  - T_REC cycles; act cleared.
  - If sw_single_step was sampled 1 at WR entry: go to STOP and set stopped=1. Otherwise go to IDLE.
- STOP:
  - On a rising edge of sw_restart, clear stopped and go to IDLE.
  - Requests are held off.
- Simultaneous requests: round-robin only; no fixed priority.
- wr_rs outside PSE, or on a non-active port, is ignored.
- Address width: ma is used in full; no wrap beyond 2**AW.

Optional Feature:
- Macro: CORE_PARITY_EN.
- When defined:
  - Core words are DW+1 bits; the extra bit stores odd parity of the data, computed in WR.
  - In RD, parity is checked at strobe.
  - On mismatch the output par_err (1 bit, sticky) is set; it is cleared only by reset.
  - Data is still returned and restored with regenerated parity.
- When undefined: no parity storage; the par_err port is absent.

Decomposition:
- Package core_mem_pkg holds:
  - the state enum (IDLE, ADDR, RD, PSE, WR, REC, STOP);
  - the select-match function;
  - the parity function.
- One sub-module, core_mem_rr_arb: NPORTS round-robin arbiter taking req and rr_ptr and returning grant index and valid.
- Sequencer, datapath and array stay in core_mem_nport.

Test Plan:
- Read: preload core[0o1234]=36'o123456701234; port0 reads. Required response:
  - addr_ack[0] 1 cycle after grant;
  - rd_rs[0] with mb_out[0] equal to the preloaded value;
  - word restored unchanged after the cycle.
- Write: port2 issues wr_rq to 0o17, then wr_rs with mb_in=36'o777. Required response: core[0o17]=0o777; rd_rs never pulses.
- Arbitration: all 4 ports request continuously. Grants are 0,1,2,3,0 with no port skipped; mb_out is zero on non-active ports.
- Select filter: sel=SEL_ID with fmc_select=1, and sel≠SEL_ID with fmc_select=0. Required response: no addr_ack; busy stays 0.
- Abort and reset:
  - Read-modify-write where rq_cyc drops in PSE: the old word is restored.
  - A separate cycle reset in WR: core is unchanged and all outputs are 0.
- Single step: sw_single_step=1 gives stopped=1 after one cycle and a second request is ignored. A sw_restart edge clears stopped and the pending request is then granted.

Source files
------------

// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_pkg
// Brief    : Shared types and helpers for the core_mem_nport memory slice:
//            sequencer state encoding, select-code match and word parity.
// Revision : 1.0  initial release
// ============================================================================
package core_mem_pkg;

  // Memory cycle sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_RD   = 3'd2,
    ST_PSE  = 3'd3,
    ST_WR   = 3'd4,
    ST_REC  = 3'd5,
    ST_STOP = 3'd6
  } core_state_e;

  // A port addresses this module when its select code equals our jumper code
  function automatic logic sel_match(input logic [3:0] code, input logic [3:0] id);
    return (code == id);
  endfunction

  // Odd parity over a word zero-extended to 64 bits (zero-extension does not
  // change the parity, so any data width up to 64 can use this)
  function automatic logic odd_par(input logic [63:0] data);
    return ~(^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_rr_arb
// Brief    : Combinational round-robin arbiter. Grants the first requesting
//            port at or after rr_ptr, wrapping modulo NPORTS.
// Revision : 1.0  initial release
// ============================================================================
module core_mem_rr_arb #(
  parameter int NPORTS = 4,
  parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic [IW-1:0]     grant,
  output logic              valid
);

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NPORTS;
      if (req[idx]) begin
        grant = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_nport.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_nport
// Brief    : NPORTS-port read-restore core memory for the membus. Round-robin
//            port arbitration, a clocked IDLE/ADDR/RD/PSE/WR/REC sequencer and
//            optional single-step stop with restart.
//            Optional macro CORE_PARITY_EN: stores an odd-parity bit with each
//            word and raises a sticky par_err on a read-strobe mismatch.
// Revision : 1.0  initial release
// ============================================================================
module core_mem_nport
  import core_mem_pkg::*;
#(
  parameter int         NPORTS = 4,
  parameter int         AW     = 14,
  parameter int         DW     = 36,
  parameter logic [3:0] SEL_ID = 4'b0000,
  parameter int         T_RD   = 5,
  parameter int         T_WR   = 5,
  parameter int         T_REC  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw_single_step,
  input  logic                 sw_restart,
  input  logic [NPORTS-1:0]    rq_cyc,
  input  logic [NPORTS-1:0]    rd_rq,
  input  logic [NPORTS-1:0]    wr_rq,
  input  logic [NPORTS-1:0]    wr_rs,
  input  logic [NPORTS-1:0]    fmc_select,
  input  logic [NPORTS*4-1:0]  sel,
  input  logic [NPORTS*AW-1:0] ma,
  input  logic [NPORTS*DW-1:0] mb_in,
  output logic [NPORTS-1:0]    addr_ack,
  output logic [NPORTS-1:0]    rd_rs,
  output logic [NPORTS*DW-1:0] mb_out,
  output logic                 stopped,
  output logic                 busy
`ifdef CORE_PARITY_EN
  ,
  output logic                 par_err
`endif
);

  localparam int c_iw    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int c_depth = 2 ** AW;
  localparam int c_tmax  = (T_RD > T_WR) ? ((T_RD > T_REC) ? T_RD : T_REC)
                                         : ((T_WR > T_REC) ? T_WR : T_REC);
  localparam int c_cw    = $clog2(c_tmax + 1);
`ifdef CORE_PARITY_EN
  localparam int c_core_w = DW + 1;
`else
  localparam int c_core_w = DW;
`endif

  // Sequencer and datapath registers
  core_state_e         r_state;
  logic [c_iw-1:0]     r_act;
  logic [AW-1:0]       r_cma;
  logic                r_cma_rd;
  logic                r_cma_wr;
  logic [DW-1:0]       r_cmb;
  logic [c_cw-1:0]     r_cnt;
  logic [c_iw-1:0]     r_rr_ptr;
  logic                r_ss;
  logic                r_stopped;
  logic                r_restart_d;

  // Core array; deliberately never reset so contents survive a reset
  logic [c_core_w-1:0] r_core [c_depth];

  logic [NPORTS-1:0]   w_req;
  logic [c_iw-1:0]     w_grant;
  logic                w_grant_vld;
  logic                w_strobe;
  logic                w_wr_last;
  logic                w_act_rq;
  logic                w_act_wr_rs;
  logic [DW-1:0]       w_act_mb_in;
  logic [c_core_w-1:0] w_core_rd;
  logic [DW-1:0]       w_word;
  logic [c_core_w-1:0] w_core_wr;

  // Per-port request qualification: cycle request, not claimed by fast
  // memory, and addressed to our select code
  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_req
      assign w_req[i] = rq_cyc[i] & ~fmc_select[i] & sel_match(sel[4*i +: 4], SEL_ID);
    end
  endgenerate

  core_mem_rr_arb #(
    .NPORTS (NPORTS),
    .IW     (c_iw)
  ) u_arb (
    .req    (w_req),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant),
    .valid  (w_grant_vld)
  );

  assign w_act_rq    = rq_cyc[r_act];
  assign w_act_wr_rs = wr_rs[r_act];
  assign w_act_mb_in = mb_in[r_act*DW +: DW];

  assign w_core_rd = r_core[r_cma];
  assign w_word    = w_core_rd[DW-1:0];
  assign w_strobe  = (r_state == ST_RD) && (r_cnt == c_cw'(1));
  assign w_wr_last = (r_state == ST_WR) && (r_cnt == c_cw'(1));

`ifdef CORE_PARITY_EN
  assign w_core_wr = {odd_par(64'(r_cmb)), r_cmb};
`else
  assign w_core_wr = r_cmb;
`endif

  // Cycle sequencer: arbitration, address latch, timing and single-step stop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_act       <= '0;
      r_cma       <= '0;
      r_cma_rd    <= 1'b0;
      r_cma_wr    <= 1'b0;
      r_cmb       <= '0;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_ss        <= 1'b0;
      r_stopped   <= 1'b0;
      r_restart_d <= 1'b0;
    end else begin
      r_restart_d <= sw_restart;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_act    <= w_grant;
            r_cma    <= ma[w_grant*AW +: AW];
            r_cma_rd <= rd_rq[w_grant];
            r_cma_wr <= wr_rq[w_grant];
            r_state  <= ST_ADDR;
            if (w_grant == c_iw'(NPORTS - 1)) begin
              r_rr_ptr <= '0;
            end else begin
              r_rr_ptr <= w_grant + 1'b1;
            end
          end
        end
        ST_ADDR: begin
          r_state <= ST_RD;
          r_cnt   <= c_cw'(T_RD);
        end
        ST_RD: begin
          if (r_cnt == c_cw'(1)) begin
            // Sense strobe: the word moves into the buffer register. The
            // array copy is left in place until the restore so that a cycle
            // abandoned by reset leaves the stored word intact.
            r_cmb   <= w_word;
            r_state <= ST_PSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_PSE: begin
          if (!r_cma_wr || w_act_wr_rs || !w_act_rq) begin
            // Write data replaces the sensed word; an abort restores it
            if (r_cma_wr && w_act_wr_rs) begin
              r_cmb <= w_act_mb_in;
            end
            r_state <= ST_WR;
            r_cnt   <= c_cw'(T_WR);
            r_ss    <= sw_single_step;
          end
        end
        ST_WR: begin
          if (r_cnt == c_cw'(1)) begin
            r_state <= ST_REC;
            r_cnt   <= c_cw'(T_REC);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_REC: begin
          if (r_cnt == c_cw'(1)) begin
            r_act <= '0;
            if (r_ss) begin
              r_state   <= ST_STOP;
              r_stopped <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (sw_restart && !r_restart_d) begin
            r_stopped <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Core array write/restore on the final WR cycle
  always_ff @(posedge clk) begin
    if (w_wr_last) begin
      r_core[r_cma] <= w_core_wr;
    end
  end

`ifdef CORE_PARITY_EN
  logic r_par_err;

  // Sticky parity error, evaluated on the stored word at the sense strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_err <= 1'b0;
    end else if (w_strobe && (w_core_rd[DW] != odd_par(64'(w_word)))) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

  // Bus outputs: one-cycle pulses to the active port only
  always_comb begin
    addr_ack = '0;
    rd_rs    = '0;
    mb_out   = '0;
    if (r_state == ST_ADDR) begin
      addr_ack[r_act] = 1'b1;
    end
    if (w_strobe && r_cma_rd) begin
      rd_rs[r_act]              = 1'b1;
      mb_out[r_act*DW +: DW]    = w_word;
    end
  end

  assign stopped = r_stopped;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_STOP);

endmodule
`default_nettype wire
